// File: rtl/line_card_xbar_ingress.sv
// Crossbar ingress negotiator: per frame it requests a crossbar path, waits for grant,
// streams the frame through and pulses release; bad destinations and grant timeouts are dropped.
module line_card_xbar_ingress #(
  parameter int  NUM_PORTS     = 50,
  parameter int  XBAR_PORT     = 0,
  parameter int  GRANT_TIMEOUT = 1024,
  parameter int  MAX_BEATS     = 1200,
  localparam int PORT_BITS     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [63:0]          s_tdata,
  input  logic [7:0]           s_tkeep,
  input  logic                 s_tlast,
  input  logic [PORT_BITS:0]   s_tdest,
  input  logic [11:0]          s_tuser,
  output logic                 req_valid,
  output logic [PORT_BITS-1:0] req_dest,
  output logic                 req_bcast,
  output logic [4:0]           req_src,
  input  logic                 grant,
  output logic                 xbar_release,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [63:0]          m_tdata,
  output logic [7:0]           m_tkeep,
  output logic                 m_tlast,
  output logic [11:0]          m_tuser,
  output logic [31:0]          drop_count,
  output logic [31:0]          trunc_count
);

  localparam int TO_W   = $clog2(GRANT_TIMEOUT + 1);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(GRANT_TIMEOUT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DROP} state_t;

  state_t               state_q, state_d;
  logic [PORT_BITS-1:0] dest_q;
  logic                 bcast_q;
  logic [11:0]          vlan_q;
  logic [TO_W-1:0]      to_cnt_q;
  logic [BEAT_W-1:0]    beat_cnt_q;
  logic                 release_q;
  logic [31:0]          drop_cnt_q;
  logic [31:0]          trunc_cnt_q;

  logic dest_bad;
  logic to_done;
  logic beat_last;
  logic beat_acc;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Broadcast frames ignore the port field; unicast ports beyond the switch are unroutable.
  assign dest_bad  = !s_tdest[PORT_BITS] && (32'(s_tdest[PORT_BITS-1:0]) >= 32'(NUM_PORTS));
  assign to_done   = (to_cnt_q == TO_LAST);
  assign beat_last = (beat_cnt_q == BEAT_LAST);
  assign beat_acc  = (state_q == XFER) && s_tvalid && m_tready;

  assign req_src      = 5'(XBAR_PORT);
  assign req_dest     = dest_q;
  assign req_bcast    = bcast_q;
  assign m_tuser      = vlan_q;
  assign xbar_release = release_q;
  assign drop_count   = drop_cnt_q;
  assign trunc_count  = trunc_cnt_q;

  // NOTE: every output and next-state is given a default before the case, so no
  // path through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    s_tready  = 1'b0;
    req_valid = 1'b0;
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tlast   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_tvalid) state_d = dest_bad ? DROP : REQ;
      end
      REQ: begin
        req_valid = 1'b1;
        if (grant)        state_d = XFER;
        else if (to_done) state_d = DROP;
      end
      XFER: begin
        req_valid = 1'b1;
        m_tvalid  = s_tvalid;
        s_tready  = m_tready;
        m_tdata   = s_tdata;
        m_tkeep   = s_tkeep;
        m_tlast   = s_tlast || beat_last;
        if (beat_acc) begin
          if (s_tlast)        state_d = IDLE;
          else if (beat_last) state_d = DROP;
        end
      end
      DROP: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      bcast_q     <= 1'b0;
      vlan_q      <= '0;
      to_cnt_q    <= '0;
      beat_cnt_q  <= '0;
      release_q   <= 1'b0;
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      release_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_tvalid) begin
            dest_q   <= s_tdest[PORT_BITS-1:0];
            bcast_q  <= s_tdest[PORT_BITS];
            vlan_q   <= s_tuser;
            to_cnt_q <= '0;
            if (dest_bad) drop_cnt_q <= sat_inc(drop_cnt_q);
          end
        end
        REQ: begin
          if (grant)        beat_cnt_q <= '0;
          else if (to_done) drop_cnt_q <= sat_inc(drop_cnt_q);
          else              to_cnt_q   <= to_cnt_q + 1'b1;
        end
        XFER: begin
          if (beat_acc) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (s_tlast) begin
              release_q <= 1'b1;
            end else if (beat_last) begin
              release_q   <= 1'b1;
              trunc_cnt_q <= sat_inc(trunc_cnt_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/line_card_xbar_ingress.md
Name: line_card_xbar_ingress

Overview:
- Sits directly downstream of the line card input buffering stage. Consumes its 64-bit routed frame stream (TDEST = {broadcast, dest port}, TUSER = VLAN) and negotiates crossbar access per frame.
- Per frame: raise a request to the crossbar arbiter, wait for grant, stream the frame, then pulse release.
- Frames are dropped if the destination is invalid or the grant times out. Oversize frames are truncated.

Parameters:
- NUM_PORTS, 50, global switch port count; PORT_BITS = $clog2(NUM_PORTS) (localparam)
- XBAR_PORT, 0, this line card's crossbar input index; driven on req_src
- GRANT_TIMEOUT, 1024, cycles to wait for grant before dropping the frame
- MAX_BEATS, 1200, maximum 64-bit beats forwarded per frame

Ports:
- clk  in  1  fabric clock
- rst  in  1  synchronous reset, active high
- s_tvalid  in  1  upstream frame beat valid
- s_tready  out  1  upstream ready
- s_tdata  in  64  frame data
- s_tkeep  in  8  byte enables
- s_tlast  in  1  last beat of frame
- s_tdest  in  PORT_BITS+1  {broadcast flag, dest port}
- s_tuser  in  12  VLAN ID
- req_valid  out  1  crossbar request asserted
- req_dest  out  PORT_BITS  requested output port
- req_bcast  out  1  broadcast request
- req_src  out  5  constant XBAR_PORT
- grant  in  1  crossbar grant, single-cycle pulse
- release  out  1  single-cycle pulse, frame finished
- m_tvalid  out  1  to crossbar
- m_tready  in  1  from crossbar
- m_tdata  out  64
- m_tkeep  out  8
- m_tlast  out  1
- m_tuser  out  12  VLAN, held constant for the frame
- drop_count  out  32  frames dropped (invalid dest or timeout), saturating
- trunc_count  out  32  frames truncated, saturating

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active high.
- Reset values: state IDLE; every output 0 (s_tready, req_valid, release, m_tvalid, m_tlast, req_dest, req_bcast, both counters). Exception: req_src is constant XBAR_PORT.
- Reset mid-frame:
  - Returns to IDLE immediately.
  - Does not pulse release.
  - Upstream is reset on the same rst, so no partial-frame resync is required.
- States: IDLE, REQ, XFER, DROP.
- IDLE:
  - s_tready = 0.
  - On s_tvalid, latch s_tdest and s_tuser without consuming the beat; clear the timeout counter.
  - If broadcast = 0 and dest port >= NUM_PORTS, go to DROP and increment drop_count. Otherwise go to REQ.
- REQ:
  - req_valid = 1, with req_dest/req_bcast taken from the latch; s_tready = 0.
  - If grant is sampled high, go to XFER next cycle and clear the beat counter.
  - Otherwise the timeout counter increments. When it reaches GRANT_TIMEOUT-1 with no grant, deassert req_valid, go to DROP, and increment drop_count.
  - Grant and timeout in the same cycle: grant wins.
- XFER:
  - Combinational pass-through: m_tvalid = s_tvalid, s_tready = m_tready, m_tdata/m_tkeep = s_*, m_tuser = latched VLAN.
  - req_valid stays 1 until the last beat is accepted.
  - A beat is accepted on s_tvalid & s_tready; the beat counter increments on each accepted beat.
  - m_tlast = s_tlast OR (beat counter == MAX_BEATS-1).
  - If an accepted beat has s_tlast, go to IDLE and pulse release next cycle.
  - If an accepted beat forced tlast without s_tlast, increment trunc_count, pulse release, and go to DROP.
- DROP:
  - s_tready = 1 and m_tvalid = 0; beats are discarded.
  - On an accepted s_tlast, go to IDLE.
  - release does not pulse for frames dropped before grant.
- Back-to-back frames: after the tlast cycle, IDLE evaluates the next header on the following cycle. Minimum gap is 2 cycles (IDLE + REQ) plus grant latency.
- Counters saturate at 0xFFFFFFFF.
- A grant outside REQ is ignored.

Test Plan:
- Unicast dest 7, VLAN 0x00A, 4 beats; grant 3 cycles after req_valid; m_tready = 1 -> req_dest = 7; 4 beats out in order with m_tlast on beat 4; m_tuser = 0x00A; release pulses once; counters stay 0.
- Broadcast (s_tdest MSB = 1, port 0) -> req_bcast = 1; frame forwarded intact.
- s_tdest port = 55 with NUM_PORTS = 50 -> no req_valid; all beats consumed; m_tvalid never high; drop_count = 1.
- GRANT_TIMEOUT = 16, grant never asserted -> req_valid high exactly 16 cycles; frame discarded; drop_count = 1; the next frame (granted) passes normally.
- MAX_BEATS = 8, 12-beat frame -> 8 beats out, m_tlast on beat 8; remaining 4 beats discarded; trunc_count = 1; exactly one release pulse.
- m_tready toggled 50% randomly during a 20-beat frame, plus rst asserted on beat 10 of a second frame -> first frame bit-exact; after rst all outputs 0 and state IDLE; no release pulse for the aborted frame.
